rr_blocking_arbiter: RTL and testbench

//  Shares one blocking-read consumer port among N_PORTS producers. All links use sync/notify handshakes.

---
 rtl/rr_blocking_arbiter_pkg.sv | 14 +
 rtl/rr_blocking_arbiter_pick.sv | 28 ++
 rtl/rr_blocking_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_blocking_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_blocking_arbiter_pkg.sv
// Shared types for the round-robin blocking-read arbiter.
// Section encoding and default pointer width.
package rr_blocking_arbiter_types;

  localparam int N_PORTS_DEF = 4;
  localparam int PTR_W = $clog2(N_PORTS_DEF);

  typedef enum logic [1:0] {
    section_scan,
    section_read,
    section_write
  } rr_blocking_arbiter_SECTIONS;

endpackage

// File: rtl/rr_blocking_arbiter_pick.sv
// Round-robin picker: first asserted req at or after ptr, with wrap.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_blocking_arbiter.sv
// N-producer to one-consumer blocking arbiter, sync/notify links.
// Define GRANT_CNT_EN for saturating per-port transfer counters.
module rr_blocking_arbiter
  import rr_blocking_arbiter_types::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32
`ifdef GRANT_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS*DATA_W-1:0]    in_data,
  input  logic [N_PORTS-1:0]           in_sync,
  output logic [N_PORTS-1:0]           in_notify,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_sync,
  output logic                         out_notify,
  output logic [$clog2(N_PORTS)-1:0]   grant_idx,
  output logic                         busy
`ifdef GRANT_CNT_EN
  ,
  output logic [N_PORTS*CNT_W-1:0]     grant_cnt
`endif
);

  localparam int PW = $clog2(N_PORTS);

  rr_blocking_arbiter_SECTIONS state, state_n;

  logic [PW-1:0]      ptr, ptr_n;
  logic [PW-1:0]      gidx_n;
  logic [N_PORTS-1:0] inn_n;
  logic [DATA_W-1:0]  od_n;
  logic               on_n;
  logic               done;
  logic               found;
  logic [PW-1:0]      pick;
  logic [DATA_W-1:0]  word;

  assign word = in_data[grant_idx*DATA_W +: DATA_W];

  rr_pick #(
    .N  (N_PORTS),
    .PW (PW)
  ) u_pick (
    .req   (in_sync),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= section_scan;
      ptr        <= '0;
      grant_idx  <= '0;
      in_notify  <= '0;
      out_data   <= '0;
      out_notify <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      grant_idx  <= gidx_n;
      in_notify  <= inn_n;
      out_data   <= od_n;
      out_notify <= on_n;
      busy       <= (state_n != section_scan);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = grant_idx;
    inn_n   = in_notify;
    od_n    = out_data;
    on_n    = out_notify;
    done    = 1'b0;
    unique case (state)
      section_scan: begin
        if (found) begin
          gidx_n      = pick;
          inn_n       = '0;
          inn_n[pick] = 1'b1;
          state_n     = section_read;
        end
      end
      section_read: begin
        inn_n = '0;
        if (in_sync[grant_idx]) begin
          od_n    = word;
          on_n    = 1'b1;
          state_n = section_write;
        end else begin
          // producer withdrew: rescan without advancing ptr
          state_n = section_scan;
        end
      end
      section_write: begin
        if (out_sync) begin
          on_n    = 1'b0;
          done    = 1'b1;
          state_n = section_scan;
          ptr_n   = (grant_idx == PW'(N_PORTS - 1))
                  ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_n = section_scan;
    endcase
  end

`ifdef GRANT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (done && grant_idx == PW'(i) &&
            grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
          grant_cnt[i*CNT_W +: CNT_W] <=
            grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_rr_blocking_arbiter.sv
// Self-checking bench for rr_blocking_arbiter.
// Scoreboard of expected (port, word) pairs popped on each offer.
module tb_rr_blocking_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
`ifdef GRANT_CNT_EN
  localparam int CW = 2;
`endif

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sync;
  logic [N-1:0]    in_notify;
  logic [DW-1:0]   out_data;
  logic            out_sync;
  logic            out_notify;
  logic [1:0]      grant_idx;
  logic            busy;
`ifdef GRANT_CNT_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  rr_blocking_arbiter #(
    .N_PORTS (N),
    .DATA_W  (DW)
`ifdef GRANT_CNT_EN
    ,
    .CNT_W   (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sync    (in_sync),
    .in_notify  (in_notify),
    .out_data   (out_data),
    .out_sync   (out_sync),
    .out_notify (out_notify),
    .grant_idx  (grant_idx),
    .busy       (busy)
`ifdef GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    in_sync  = '0;
    out_sync = 1'b0;
    in_data  = '0;
    sb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(output bit ok);
    int n = 0;
    while (!out_notify && n < 20) begin
      tick();
      n++;
    end
    ok = out_notify;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    n_checks++;
    if (busy !== 1'b0 || out_notify !== 1'b0 || in_notify !== '0 ||
        out_data !== '0 || grant_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_init: busy=%b on=%b inn=%b od=%h gi=%0d want 0",
               busy, out_notify, in_notify, out_data, grant_idx);
    end
    in_sync = 4'b0010;
    set_word(1, 32'hDEAD_0001);
    tick();
    tick();
    n_checks++;
    if (out_notify !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup: out_notify=%b want 1", out_notify);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_notify !== 1'b0 || in_notify !== '0 || busy !== 1'b0 ||
        out_data !== '0 || grant_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_async: on=%b inn=%b busy=%b od=%h gi=%0d want 0",
               out_notify, in_notify, busy, out_data, grant_idx);
    end
`ifdef GRANT_CNT_EN
    n_checks++;
    if (grant_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: grant_cnt=%h want 0", grant_cnt);
    end
`endif
    in_sync = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    e = '0;
    n_checks++;
    if (sb.size() != 0 || e.port !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sb: size=%0d want 0", sb.size());
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    out_sync = 1'b1;
    in_sync  = 4'b0100;
    set_word(2, 32'h0000_1234);
    sb.push_back('{port: 2'd2, data: 32'h1234});
    tick();
    n_checks++;
    if (in_notify !== 4'b0100 || grant_idx !== 2'd2 || out_notify !== 1'b0
        || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: inn=%b gi=%0d on=%b busy=%b want 0100 2 0 1",
               in_notify, grant_idx, out_notify, busy);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if (out_notify !== 1'b1 || out_data !== e.data ||
        grant_idx !== e.port || in_notify !== '0) begin
      n_fail++;
      $display("FAIL single_offer: on=%b od=%h gi=%0d inn=%b want 1 %h %0d 0",
               out_notify, out_data, grant_idx, in_notify, e.data, e.port);
    end
    in_sync = '0;
    tick();
    n_checks++;
    if (out_notify !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: on=%b busy=%b want 0 0", out_notify, busy);
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    bit   ok;
    int   last;
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 32'hA0 + i);
    out_sync = 1'b1;
    in_sync  = 4'b1111;
    for (int k = 0; k < 5; k++)
      sb.push_back('{port: 2'(k % N), data: 32'hA0 + (k % N)});
    last = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_offer(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL fair_timeout[%0d]: no out_notify within bound", k);
      end else if (grant_idx !== e.port || out_data !== e.data) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: gi=%0d od=%h want %0d %h",
                 k, grant_idx, out_data, e.port, e.data);
      end
      n_checks++;
      if (cyc - last !== (k == 0 ? 2 : 3)) begin
        n_fail++;
        $display("FAIL fair_rate[%0d]: gap=%0d want %0d",
                 k, cyc - last, (k == 0 ? 2 : 3));
      end
      last = cyc;
      tick();
      n_checks++;
      if ($countones(in_notify) > 1) begin
        n_fail++;
        $display("FAIL fair_onehot[%0d]: inn=%b want <=1 bit", k, in_notify);
      end
    end
    in_sync = '0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    out_sync = 1'b0;
    in_sync  = 4'b0010;
    set_word(1, 32'h55);
    sb.push_back('{port: 2'd1, data: 32'h55});
    tick();
    tick();
    in_sync = 4'b1111;
    set_word(1, 32'h99);
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (out_notify !== 1'b1 || out_data !== 32'h55 || in_notify !== '0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: on=%b od=%h inn=%b want 1 55 0",
                 k, out_notify, out_data, in_notify);
      end
    end
    e = sb.pop_front();
    n_checks++;
    if (out_data !== e.data || grant_idx !== e.port) begin
      n_fail++;
      $display("FAIL bp_word: od=%h gi=%0d want %h %0d",
               out_data, grant_idx, e.data, e.port);
    end
    out_sync = 1'b1;
    tick();
    n_checks++;
    if (out_notify !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: on=%b want 0", out_notify);
    end
    tick();
    n_checks++;
    if (in_notify !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_next: inn=%b want 0100", in_notify);
    end
    in_sync = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    out_sync = 1'b1;
    in_sync  = 4'b0001;
    tick();
    tick();
    in_sync = '0;
    tick();
    in_sync = 4'b0010;
    tick();
    n_checks++;
    if (in_notify !== 4'b0010) begin
      n_fail++;
      $display("FAIL wd_grant: inn=%b want 0010", in_notify);
    end
    in_sync = '0;
    tick();
    n_checks++;
    if (in_notify !== '0 || out_notify !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_abort: inn=%b on=%b busy=%b want 0 0 0",
               in_notify, out_notify, busy);
    end
    in_sync = 4'b1111;
    tick();
    n_checks++;
    if (in_notify !== 4'b0010 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL wd_ptr: inn=%b gi=%0d want 0010 1", in_notify, grant_idx);
    end
    in_sync = '0;
  endtask

  task automatic test_persistent();
    exp_t e;
    bit   ok;
    do_reset();
    out_sync = 1'b1;
    in_sync  = 4'b1000;
    set_word(3, 32'hC3);
    for (int k = 0; k < 5; k++) sb.push_back('{port: 2'd3, data: 32'hC3});
    for (int k = 0; k < 5; k++) begin
      wait_offer(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || grant_idx !== e.port || out_data !== e.data) begin
        n_fail++;
        $display("FAIL persist[%0d]: ok=%0d gi=%0d od=%h want %0d %h",
                 k, ok, grant_idx, out_data, e.port, e.data);
      end
      tick();
    end
    in_sync = '0;
`ifdef GRANT_CNT_EN
    n_checks++;
    if (grant_cnt !== {2'd3, 2'd0, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL cnt_sat: grant_cnt=%b want 11000000", grant_cnt);
    end
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_sync  = '0;
    in_data  = '0;
    out_sync = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_withdraw();
    test_persistent();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
